mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one unified instruction/data memory between the pipeline's fetch stage and memory stage. Two requesters (fetch, data) are granted one at a time. Each granted request is latched and presented to the memory until the memory acknowledges it. The arbiter also drives stall requests that the hazard unit ORs into its F-stage and M-stage stalls.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one unified memory between fetch and data
// requesters, with data priority that alternates under contention so fetch is never starved.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] irdata,
   output logic              iready,
   input  logic              dreq,
   input  logic              dwe,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dwdata,
   output logic [DATA_W-1:0] drdata,
   output logic              dready,
   output logic              stallf,
   output logic              stallm,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2
   } state_t;

   state_t state_r;
   state_t next_state_s;
   logic   last_d_r;
   logic   ack_i_s;
   logic   ack_d_s;
   logic   decide_s;
   logic   i_cand_s;
   logic   d_cand_s;

   // Grant decision: a requester whose access completes this cycle is not a candidate.
   always_comb begin
      next_state_s = state_r;
      ack_i_s      = (state_r == IACC) && mem_ack;
      ack_d_s      = (state_r == DACC) && mem_ack;
      decide_s     = (state_r == IDLE) || ack_i_s || ack_d_s;
      i_cand_s     = ireq && !ack_i_s;
      d_cand_s     = dreq && !ack_d_s;
      if (decide_s) begin
         if (i_cand_s && d_cand_s) begin
            next_state_s = last_d_r ? IACC : DACC;
         end else if (d_cand_s) begin
            next_state_s = DACC;
         end else if (i_cand_s) begin
            next_state_s = IACC;
         end else begin
            next_state_s = IDLE;
         end
      end else begin
         next_state_s = state_r;
      end
   end

   assign stallf = ireq && !iready;
   assign stallm = dreq && !dready;

   // State, memory-side request registers and requester result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         last_d_r  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         irdata    <= {DATA_W{1'b0}};
         drdata    <= {DATA_W{1'b0}};
         iready    <= 1'b0;
         dready    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         iready  <= 1'b0;
         dready  <= 1'b0;
         if (ack_i_s) begin
            irdata   <= mem_rdata;
            iready   <= 1'b1;
            last_d_r <= 1'b0;
         end else if (ack_d_s) begin
            dready   <= 1'b1;
            last_d_r <= 1'b1;
            // Stores complete without touching the load result register.
            if (!mem_we) begin
               drdata <= mem_rdata;
            end
         end
         if (decide_s) begin
            case (next_state_s)
               IACC: begin
                  mem_addr <= iaddr;
                  mem_we   <= 1'b0;
                  mem_req  <= 1'b1;
               end
               DACC: begin
                  mem_addr  <= daddr;
                  mem_we    <= dwe;
                  mem_wdata <= dwdata;
                  mem_req   <= 1'b1;
               end
               default: begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change 1 ns after the
// rising edge, outputs are compared on the falling edge.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              ireq;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] irdata;
   logic              iready;
   logic              dreq;
   logic              dwe;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dwdata;
   logic [DATA_W-1:0] drdata;
   logic              dready;
   logic              stallf;
   logic              stallm;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
      .drdata(drdata), .dready(dready),
      .stallf(stallf), .stallm(stallm),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; ireq = 1'b0; iaddr = 32'h0; dreq = 1'b0; dwe = 1'b0;
      daddr = 32'h0; dwdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;

      // Reset values
      repeat (2) next_cycle();
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_irdata", irdata, 32'h0);
      chk("rst_drdata", drdata, 32'h0);
      chk("rst_iready", iready, 1'b0);
      chk("rst_dready", dready, 1'b0);

      // Single fetch with immediate ack
      next_cycle();
      reset = 1'b0; ireq = 1'b1; iaddr = 32'h40;
      @(negedge clk);
      chk("f_c1_stallf", stallf, 1'b1);
      chk("f_c1_mem_req", mem_req, 1'b0);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h20080005;
      @(negedge clk);
      chk("f_c2_mem_req", mem_req, 1'b1);
      chk("f_c2_mem_addr", mem_addr, 32'h40);
      chk("f_c2_mem_we", mem_we, 1'b0);
      chk("f_c2_stallf", stallf, 1'b1);
      chk("f_c2_iready", iready, 1'b0);
      next_cycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("f_c3_iready", iready, 1'b1);
      chk("f_c3_irdata", irdata, 32'h20080005);
      chk("f_c3_stallf", stallf, 1'b0);
      ireq = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("f_c4_iready", iready, 1'b0);
      chk("f_c4_mem_req", mem_req, 1'b0);
      chk("f_c4_irdata_hold", irdata, 32'h20080005);

      // Simultaneous requests from idle with last_d=0, then sustained contention
      next_cycle();
      ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; iaddr = 32'h100; daddr = 32'h200;
      @(negedge clk);
      chk("c_stallf", stallf, 1'b1);
      chk("c_stallm", stallm, 1'b1);
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         mem_ack = 1'b1; mem_rdata = 32'h1000 + k;
         @(negedge clk);
         chk("c_mem_req", mem_req, 1'b1);
         chk("c_grant_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h100);
         if (k > 0) begin
            if (k % 2 == 1) begin
               chk("c_dready", dready, 1'b1);
               chk("c_drdata", drdata, 32'h1000 + k - 1);
               chk("c_stallm_ready", stallm, 1'b0);
               chk("c_stallf_wait", stallf, 1'b1);
            end else begin
               chk("c_iready", iready, 1'b1);
               chk("c_irdata", irdata, 32'h1000 + k - 1);
               chk("c_stallf_ready", stallf, 1'b0);
               chk("c_stallm_wait", stallm, 1'b1);
            end
         end
         if (k == 5) dreq = 1'b0;
      end
      next_cycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("c_last_iready", iready, 1'b1);
      chk("c_last_irdata", irdata, 32'h1005);
      chk("c_last_dready", dready, 1'b0);
      chk("c_end_mem_req", mem_req, 1'b0);
      ireq = 1'b0;

      // Data write with delayed ack
      next_cycle();
      dreq = 1'b1; dwe = 1'b1; daddr = 32'h54; dwdata = 32'h7;
      @(negedge clk);
      chk("w_stallm_req", stallm, 1'b1);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         @(negedge clk);
         chk("w_mem_req", mem_req, 1'b1);
         chk("w_mem_we", mem_we, 1'b1);
         chk("w_mem_addr", mem_addr, 32'h54);
         chk("w_mem_wdata", mem_wdata, 32'h7);
         chk("w_dready", dready, 1'b0);
         chk("w_stallm", stallm, 1'b1);
      end
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("w_ack_mem_we", mem_we, 1'b1);
      chk("w_ack_stallm", stallm, 1'b1);
      next_cycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("w_dready", dready, 1'b1);
      chk("w_drdata_kept", drdata, 32'h1004);
      chk("w_stallm_ready", stallm, 1'b0);
      chk("w_mem_req_drop", mem_req, 1'b0);
      chk("w_mem_we_drop", mem_we, 1'b0);
      dreq = 1'b0; dwe = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("w_dready_pulse", dready, 1'b0);

      // Reset in the middle of a data access, then a late ack
      next_cycle();
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h300;
      next_cycle();
      @(negedge clk);
      chk("r_mem_req", mem_req, 1'b1);
      chk("r_mem_addr", mem_addr, 32'h300);
      next_cycle();
      reset = 1'b1; dreq = 1'b0;
      next_cycle();
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD;
      @(negedge clk);
      chk("r_mem_req_after", mem_req, 1'b0);
      chk("r_mem_addr_after", mem_addr, 32'h0);
      chk("r_mem_wdata_after", mem_wdata, 32'h0);
      chk("r_irdata_after", irdata, 32'h0);
      chk("r_drdata_after", drdata, 32'h0);
      chk("r_dready_after", dready, 1'b0);
      next_cycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chk("r_late_dready", dready, 1'b0);
      chk("r_late_drdata", drdata, 32'h0);
      chk("r_late_mem_req", mem_req, 1'b0);

      // Arbiter is idle again: a fresh fetch is granted normally
      next_cycle();
      ireq = 1'b1; iaddr = 32'h80;
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      chk("p_mem_req", mem_req, 1'b1);
      chk("p_mem_addr", mem_addr, 32'h80);
      next_cycle();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("p_iready", iready, 1'b1);
      chk("p_irdata", irdata, 32'h12345678);
      ireq = 1'b0;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
